// File: rtl/simproc_mem_arbiter.sv
// Memory arbiter for SimProc. The processor control FSM (port C) and a
// host/debug loader (port H) share one single-port memory. C normally wins.
// H is protected from starvation by a saturating wait counter and may take a
// lock for back-to-back program loading. Read data returns one cycle after
// mem_re and is routed to whichever port issued the read.
//
// Handshake: a requester holds req/we/addr/wdata stable until its gnt is
// high. A cycle with gnt high is the transfer. A write completes in that
// cycle. A read returns rvalid/rdata exactly one cycle later. Nothing is
// queued, and rvalid pulses for a single cycle without back-pressure.
module simproc_mem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic              cpu_stall,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    input  logic              h_lock,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    output logic              h_locked,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        ST_OPEN = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_C    = 2'd1,
        OWN_H    = 2'd2
    } owner_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    state_t            state_q, state_d;
    logic              h_locked_q;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    owner_t            rd_owner_q, rd_owner_d;
    logic [DATA_W-1:0] c_rdata_q, h_rdata_q;

    logic              c_gnt_w, h_gnt_w;
    logic              h_due;
    logic              c_rvalid_w, h_rvalid_w;

    // H is owed the memory once it has been denied WAIT_LIMIT cycles in a row
    assign h_due = (wait_cnt_q == WAIT_LIMIT);

    // Grant decision: C by default, H when alone, overdue, or holding the lock
    always_comb begin
        c_gnt_w = 1'b0;
        h_gnt_w = 1'b0;
        if (!reset) begin
            if (state_q == ST_LOCK) begin
                h_gnt_w = h_req;
            end else if (c_req && h_req) begin
                if (h_due) begin
                    h_gnt_w = 1'b1;
                end else begin
                    c_gnt_w = 1'b1;
                end
            end else begin
                c_gnt_w = c_req;
                h_gnt_w = h_req;
            end
        end
    end

    assign c_gnt     = c_gnt_w;
    assign h_gnt     = h_gnt_w;
    assign cpu_stall = c_req & ~c_gnt_w;
    assign h_locked  = h_locked_q;

    // Memory mux: the granted port drives the memory, idle bus is all zeros
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (c_gnt_w) begin
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
            mem_we    = c_we;
            mem_re    = ~c_we;
        end else if (h_gnt_w) begin
            mem_addr  = h_addr;
            mem_wdata = h_wdata;
            mem_we    = h_we;
            mem_re    = ~h_we;
        end
    end

    // Next-state for the lock FSM, the starvation counter and the read owner
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OPEN: if (h_gnt_w && h_lock) state_d = ST_LOCK;
            ST_LOCK: if (!h_lock)           state_d = ST_OPEN;
            default:                        state_d = ST_OPEN;
        endcase

        wait_cnt_d = wait_cnt_q;
        if (h_gnt_w || !h_req) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != WAIT_LIMIT) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end

        rd_owner_d = OWN_NONE;
        if (c_gnt_w && !c_we) begin
            rd_owner_d = OWN_C;
        end else if (h_gnt_w && !h_we) begin
            rd_owner_d = OWN_H;
        end
    end

    // A read in flight while reset is high is dropped, never delivered
    assign c_rvalid_w = (rd_owner_q == OWN_C) && !reset;
    assign h_rvalid_w = (rd_owner_q == OWN_H) && !reset;

    assign c_rvalid = c_rvalid_w;
    assign h_rvalid = h_rvalid_w;
    // Returned data passes straight through on its cycle, then is held
    assign c_rdata  = c_rvalid_w ? mem_rdata : c_rdata_q;
    assign h_rdata  = h_rvalid_w ? mem_rdata : h_rdata_q;

    // Lock FSM with registered h_locked flag, wait counter and read owner
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= ST_OPEN;
            h_locked_q <= 1'b0;
            wait_cnt_q <= 4'd0;
            rd_owner_q <= OWN_NONE;
        end else begin
            state_q    <= state_d;
            h_locked_q <= (state_d == ST_LOCK);
            wait_cnt_q <= wait_cnt_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Hold the last delivered read data per port
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            c_rdata_q <= '0;
            h_rdata_q <= '0;
        end else begin
            if (c_rvalid_w) c_rdata_q <= mem_rdata;
            if (h_rvalid_w) h_rdata_q <= mem_rdata;
        end
    end

endmodule
